// File: rtl/sad_pkg.sv
// Shared types and helpers for the SAD stream engine.
package sad_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } sad_state_e;

    // Result width that can hold block_pixels maximal differences without overflow.
    function automatic int unsigned sad_width(input int unsigned width,
                                              input int unsigned block_pixels);
        return width + $clog2(block_pixels);
    endfunction

    // Bit offset of pixel lane `lane` inside a packed lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sad_lane_tree.sv
// Per-lane absolute difference (stage 1) and registered lane adder tree (stage 2).
module sad_lane_tree
    import sad_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 8,
    localparam int unsigned SUM_W = WIDTH + $clog2(LANES)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic                   first_i,
    input  logic                   last_i,
    input  logic [LANES*WIDTH-1:0] ori_bus_i,
    input  logic [LANES*WIDTH-1:0] can_bus_i,
    output logic                   valid_o,
    output logic                   first_o,
    output logic                   last_o,
    output logic [SUM_W-1:0]       sum_o,
    output logic                   busy_o,
    output logic                   last_busy_o
);

    logic [WIDTH-1:0] ori_px [LANES];
    logic [WIDTH-1:0] can_px [LANES];
    logic [WIDTH-1:0] diff_d [LANES];
    logic [WIDTH-1:0] diff_q [LANES];
    logic             s1_valid_q, s1_first_q, s1_last_q;
    logic [SUM_W-1:0] sum_d, sum_q;
    logic             s2_valid_q, s2_first_q, s2_last_q;

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            ori_px[k] = ori_bus_i[lane_lsb(k, WIDTH) +: WIDTH];
            can_px[k] = can_bus_i[lane_lsb(k, WIDTH) +: WIDTH];
            diff_d[k] = (ori_px[k] > can_px[k]) ? ori_px[k] - can_px[k]
                                                : can_px[k] - ori_px[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                diff_q[k] <= '0;
            end
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= valid_i;
            if (valid_i) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    diff_q[k] <= diff_d[k];
                end
                s1_first_q <= first_i;
                s1_last_q  <= last_i;
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            sum_d = sum_d + SUM_W'(diff_q[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q      <= sum_d;
                s2_first_q <= s1_first_q;
                s2_last_q  <= s1_last_q;
            end
        end
    end

    assign valid_o     = s2_valid_q;
    assign first_o     = s2_first_q;
    assign last_o      = s2_last_q;
    assign sum_o       = sum_q;
    assign busy_o      = s1_valid_q | s2_valid_q;
    assign last_busy_o = (s1_valid_q & s1_last_q) | (s2_valid_q & s2_last_q);

endmodule

// File: rtl/sad_stream_engine.sv
// Pipelined block SAD engine: valid/ready pixel beats in, valid/ack block results out.
// Define SAD_MIN_TRACK_EN to build the running-minimum tracker (otherwise min outputs are 0).
module sad_stream_engine
    import sad_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned LANES        = 8,
    parameter int unsigned BLOCK_PIXELS = 32,
    parameter int unsigned CAND_IDX_W   = 8,
    localparam int unsigned SAD_W       = sad_width(WIDTH, BLOCK_PIXELS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   init_i,
    input  logic                   finish_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES*WIDTH-1:0] ori_bus_i,
    input  logic [LANES*WIDTH-1:0] can_bus_i,
    output logic [SAD_W-1:0]       out_sad_o,
    output logic [CAND_IDX_W-1:0]  out_idx_o,
    output logic [SAD_W-1:0]       out_min_sad_o,
    output logic [CAND_IDX_W-1:0]  out_min_idx_o,
    output logic                   out_valid_o,
    input  logic                   ack_i,
    output logic                   done_o
);

    localparam int unsigned BEATS  = BLOCK_PIXELS / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SUM_W  = WIDTH + $clog2(LANES);
    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

    sad_state_e            state_q, state_d;
    logic                  finish_q, finish_d;
    logic                  done_q, done_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [CAND_IDX_W-1:0] cand_idx_q, cand_idx_d;
    logic [SAD_W-1:0]      acc_q, acc_d;
    logic                  acc_last_q, acc_last_d;
    logic [SAD_W-1:0]      out_sad_q, out_sad_d;
    logic [CAND_IDX_W-1:0] out_idx_q, out_idx_d;
    logic                  out_valid_q, out_valid_d;

    logic             tree_valid, tree_first, tree_last, tree_busy, tree_last_busy;
    logic [SUM_W-1:0] tree_sum;
    logic             accept, beat_first, beat_last, start, pipe_empty;

    assign beat_first = (beat_cnt_q == '0);
    assign beat_last  = (beat_cnt_q == LastBeat);
    assign start      = (state_q == StIdle) && init_i;
    assign pipe_empty = !tree_busy && !acc_last_q;

    // Only one block is ever in flight: intake closes after a last beat until its result is taken.
    assign in_ready_o = (state_q == StRun) && !out_valid_q && !tree_last_busy && !acc_last_q
                        && !(finish_q && beat_first);
    assign accept     = in_valid_i && in_ready_o;

    sad_lane_tree #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_lane_tree (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (accept),
        .first_i     (beat_first),
        .last_i      (beat_last),
        .ori_bus_i   (ori_bus_i),
        .can_bus_i   (can_bus_i),
        .valid_o     (tree_valid),
        .first_o     (tree_first),
        .last_o      (tree_last),
        .sum_o       (tree_sum),
        .busy_o      (tree_busy),
        .last_busy_o (tree_last_busy)
    );

    always_comb begin
        state_d  = state_q;
        finish_d = finish_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (init_i) begin
                    state_d  = StRun;
                    finish_d = 1'b0;
                end
            end
            StRun: begin
                if (finish_i) begin
                    finish_d = 1'b1;
                end
                if (finish_q && beat_first && pipe_empty && !out_valid_q) begin
                    state_d  = StIdle;
                    finish_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        cand_idx_d  = cand_idx_q;
        acc_d       = acc_q;
        acc_last_d  = 1'b0;
        out_sad_d   = out_sad_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;

        if (start) begin
            beat_cnt_d = '0;
            cand_idx_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;
        end

        if (tree_valid) begin
            acc_d      = tree_first ? SAD_W'(tree_sum) : acc_q + SAD_W'(tree_sum);
            acc_last_d = tree_last;
        end

        if (out_valid_q && ack_i) begin
            out_valid_d = 1'b0;
        end
        if (acc_last_q) begin
            out_valid_d = 1'b1;
            out_sad_d   = acc_q;
            out_idx_d   = cand_idx_q;
            cand_idx_d  = cand_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            finish_q    <= 1'b0;
            done_q      <= 1'b0;
            beat_cnt_q  <= '0;
            cand_idx_q  <= '0;
            acc_q       <= '0;
            acc_last_q  <= 1'b0;
            out_sad_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            finish_q    <= finish_d;
            done_q      <= done_d;
            beat_cnt_q  <= beat_cnt_d;
            cand_idx_q  <= cand_idx_d;
            acc_q       <= acc_d;
            acc_last_q  <= acc_last_d;
            out_sad_q   <= out_sad_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_sad_o   = out_sad_q;
    assign out_idx_o   = out_idx_q;
    assign out_valid_o = out_valid_q;
    assign done_o      = done_q;

`ifdef SAD_MIN_TRACK_EN
    logic [SAD_W-1:0]      min_sad_q, min_sad_d;
    logic [CAND_IDX_W-1:0] min_idx_q, min_idx_d;
    logic                  min_seen_q, min_seen_d;

    // Strict less-than keeps the earlier index on ties.
    always_comb begin
        min_sad_d  = min_sad_q;
        min_idx_d  = min_idx_q;
        min_seen_d = min_seen_q;
        if (start) begin
            min_sad_d  = '0;
            min_idx_d  = '0;
            min_seen_d = 1'b0;
        end else if (acc_last_q && (!min_seen_q || acc_q < min_sad_q)) begin
            min_sad_d  = acc_q;
            min_idx_d  = cand_idx_q;
            min_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            min_sad_q  <= '0;
            min_idx_q  <= '0;
            min_seen_q <= 1'b0;
        end else begin
            min_sad_q  <= min_sad_d;
            min_idx_q  <= min_idx_d;
            min_seen_q <= min_seen_d;
        end
    end

    assign out_min_sad_o = min_sad_q;
    assign out_min_idx_o = min_idx_q;
`else
    assign out_min_sad_o = '0;
    assign out_min_idx_o = '0;
`endif

endmodule

// File: tb/tb_sad_stream_engine.sv
// Randomised self-checking bench for sad_stream_engine against a block-level SAD model.
module tb_sad_stream_engine;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned LANES        = 8;
    localparam int unsigned BLOCK_PIXELS = 32;
    localparam int unsigned CAND_IDX_W   = 8;
    localparam int unsigned BEATS        = BLOCK_PIXELS / LANES;
    localparam int unsigned SAD_W        = 13;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   init_i, finish_i, in_valid_i, ack_i;
    logic                   in_ready_o, out_valid_o, done_o;
    logic [LANES*WIDTH-1:0] ori_bus_i, can_bus_i;
    logic [SAD_W-1:0]       out_sad_o, out_min_sad_o;
    logic [CAND_IDX_W-1:0]  out_idx_o, out_min_idx_o;

    always #5 clk_i = ~clk_i;

    sad_stream_engine #(
        .WIDTH        (WIDTH),
        .LANES        (LANES),
        .BLOCK_PIXELS (BLOCK_PIXELS),
        .CAND_IDX_W   (CAND_IDX_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .init_i        (init_i),
        .finish_i      (finish_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .ori_bus_i     (ori_bus_i),
        .can_bus_i     (can_bus_i),
        .out_sad_o     (out_sad_o),
        .out_idx_o     (out_idx_o),
        .out_min_sad_o (out_min_sad_o),
        .out_min_idx_o (out_min_idx_o),
        .out_valid_o   (out_valid_o),
        .ack_i         (ack_i),
        .done_o        (done_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", tag, got, exp);
        end
    endtask

    // Reference model: block pixels, expected candidate index and running minimum.
    logic [WIDTH-1:0] ori_px [BLOCK_PIXELS];
    logic [WIDTH-1:0] can_px [BLOCK_PIXELS];
    int m_idx, m_min_sad, m_min_idx;
    bit m_min_seen;

    function automatic int block_sad();
        int s = 0;
        for (int i = 0; i < int'(BLOCK_PIXELS); i++) begin
            int d = int'(ori_px[i]) - int'(can_px[i]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    function automatic int exp_min_sad();
`ifdef SAD_MIN_TRACK_EN
        return m_min_sad;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_min_idx();
`ifdef SAD_MIN_TRACK_EN
        return m_min_idx;
`else
        return 0;
`endif
    endfunction

    task automatic model_init();
        m_idx      = 0;
        m_min_sad  = 0;
        m_min_idx  = 0;
        m_min_seen = 1'b0;
    endtask

    task automatic fill_const(input int o, input int c);
        for (int i = 0; i < int'(BLOCK_PIXELS); i++) begin
            ori_px[i] = WIDTH'(o);
            can_px[i] = WIDTH'(c);
        end
    endtask

    task automatic fill_rand();
        int mode = $urandom_range(3);
        for (int i = 0; i < int'(BLOCK_PIXELS); i++) begin
            ori_px[i] = WIDTH'($urandom);
            can_px[i] = (mode == 0) ? ori_px[i] : WIDTH'($urandom);
            if (mode == 1) can_px[i] = ~ori_px[i];
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_beat(input int b);
        for (int k = 0; k < int'(LANES); k++) begin
            ori_bus_i[k*WIDTH +: WIDTH] = ori_px[b*LANES + k];
            can_bus_i[k*WIDTH +: WIDTH] = can_px[b*LANES + k];
        end
    endtask

    task automatic do_init();
        init_i = 1'b1;
        step();
        init_i = 1'b0;
        model_init();
    endtask

    // Sends one block with random in_valid gaps; finish_i pulses with beat finish_beat.
    task automatic send_block(input int gap_pct, input int finish_beat);
        for (int b = 0; b < int'(BEATS); b++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid_i = 1'b0;
                step();
            end
            in_valid_i = 1'b1;
            drive_beat(b);
            finish_i = (b == finish_beat);
            for (int w = 0; w < 50 && !in_ready_o; w++) begin
                step();
                finish_i = 1'b0;
            end
            if (!in_ready_o) begin
                check_eq("beat_ready", in_ready_o, 1);
                in_valid_i = 1'b0;
                return;
            end
            step();
            finish_i = 1'b0;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic collect(input int ack_delay);
        int cyc = 0;
        int sad = block_sad();
        while (!out_valid_o && cyc < 20) begin
            step();
            cyc++;
        end
        check_eq("out_valid", out_valid_o, 1);
        check_eq("latency", cyc, 3);
        check_eq("out_sad", out_sad_o, sad);
        check_eq("out_idx", out_idx_o, m_idx);
        if (!m_min_seen || sad < m_min_sad) begin
            m_min_sad = sad;
            m_min_idx = m_idx;
        end
        m_min_seen = 1'b1;
        m_idx = (m_idx + 1) % (1 << CAND_IDX_W);
        check_eq("min_sad", out_min_sad_o, exp_min_sad());
        check_eq("min_idx", out_min_idx_o, exp_min_idx());
        for (int i = 0; i < ack_delay; i++) begin
            step();
            check_eq("hold_valid", out_valid_o, 1);
            check_eq("hold_sad", out_sad_o, sad);
            check_eq("hold_ready", in_ready_o, 0);
        end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check_eq("valid_after_ack", out_valid_o, 0);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done_o && cyc < 10) begin
            step();
            cyc++;
        end
        check_eq("done_pulse", done_o, 1);
        step();
        check_eq("done_width", done_o, 0);
        in_valid_i = 1'b1;
        #1;
        check_eq("idle_ready", in_ready_o, 0);
        in_valid_i = 1'b0;
    endtask

    initial begin
        init_i     = 1'b0;
        finish_i   = 1'b0;
        in_valid_i = 1'b0;
        ack_i      = 1'b0;
        ori_bus_i  = '0;
        can_bus_i  = '0;
        model_init();
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_sad", out_sad_o, 0);
        check_eq("rst_idx", out_idx_o, 0);
        check_eq("rst_valid", out_valid_o, 0);
        check_eq("rst_ready", in_ready_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_min_sad", out_min_sad_o, 0);
        rst_ni = 1'b1;
        step();
        check_eq("idle_ready0", in_ready_o, 0);
        do_init();
        check_eq("run_ready", in_ready_o, 1);

        // Fixed blocks: uniform difference, full-scale both ways, long ack hold.
        fill_const(200, 100);
        send_block(0, -1);
        collect(1);
        fill_const(0, 255);
        send_block(0, -1);
        collect(0);
        fill_const(255, 0);
        send_block(0, -1);
        collect(0);
        fill_rand();
        send_block(30, -1);
        collect(10);

        repeat (16) begin
            fill_rand();
            send_block($urandom_range(40), -1);
            collect($urandom_range(4));
        end

        // finish during beat 2: block completes, then done after ack.
        fill_rand();
        send_block(20, 2);
        collect(2);
        wait_done();
        check_eq("idle_min_sad", out_min_sad_o, exp_min_sad());

        // init and finish together in IDLE: init wins.
        init_i   = 1'b1;
        finish_i = 1'b1;
        step();
        init_i   = 1'b0;
        finish_i = 1'b0;
        model_init();
        check_eq("init_wins_ready", in_ready_o, 1);
        check_eq("init_min_clear", out_min_sad_o, 0);
        finish_i = 1'b1;
        step();
        finish_i = 1'b0;
        check_eq("finish_empty_ready", in_ready_o, 0);
        wait_done();

        // Minimum tracking with SADs 500, 120, 120.
        do_init();
        fill_const(0, 0);
        ori_px[0] = 8'd255;
        ori_px[5] = 8'd245;
        send_block(10, -1);
        collect(1);
        fill_const(0, 0);
        can_px[3] = 8'd120;
        send_block(10, -1);
        collect(1);
        fill_const(0, 0);
        ori_px[31] = 8'd120;
        send_block(10, -1);
        collect(1);
        check_eq("min_final_sad", out_min_sad_o, exp_min_sad());
        check_eq("min_final_idx", out_min_idx_o, exp_min_idx());

        // Reset asserted during beat 2 of a block.
        fill_rand();
        in_valid_i = 1'b1;
        drive_beat(0);
        step();
        drive_beat(1);
        step();
        drive_beat(2);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("amid_rst_sad", out_sad_o, 0);
        check_eq("amid_rst_idx", out_idx_o, 0);
        check_eq("amid_rst_valid", out_valid_o, 0);
        check_eq("amid_rst_ready", in_ready_o, 0);
        check_eq("amid_rst_min", out_min_sad_o, 0);
        in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b1;
        model_init();
        step();
        repeat (5) begin
            step();
            check_eq("post_rst_valid", out_valid_o, 0);
        end
        do_init();
        fill_rand();
        send_block(20, -1);
        collect(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
